// File: rtl/priv_access_guard.sv
// Privilege access guard: checks register requests against a protected-address table,
// counts violations and locks out further requests once a violation budget is exhausted.
module priv_access_guard #(
    parameter int ADDR_W     = 12,
    parameter int NUM_REGION = 4,
    parameter int VIOL_MAX   = 3,
    parameter int CNT_W      = 4,
    localparam int IDX_W     = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_read_i,
    input  logic              req_write_i,
    input  logic [1:0]        req_priv_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    output logic              rsp_except_o,
    input  logic              cfg_we_i,
    input  logic [1:0]        cfg_priv_i,
    input  logic [IDX_W-1:0]  cfg_idx_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [1:0]        cfg_min_priv_i,
    input  logic              cfg_lock_i,
    output logic              cfg_err_o,
    input  logic              clr_i,
    output logic              locked_o,
    output logic [CNT_W-1:0]  viol_cnt_o
);

    typedef enum logic [1:0] {IDLE, RESP, LOCK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] VIOL_LIM = CNT_W'(VIOL_MAX);

    state_t              r_state;
    state_t              w_next;
    logic                r_valid    [NUM_REGION];
    logic [ADDR_W-1:0]   r_addr     [NUM_REGION];
    logic [1:0]          r_min_priv [NUM_REGION];
    logic                r_lock     [NUM_REGION];
    logic                r_except;
    logic                r_cfg_err;
    logic [CNT_W-1:0]    r_viol_cnt;

    logic                w_hit;
    logic [1:0]          w_hit_min;
    logic                w_deny;
    logic                w_idx_ok;
    logic                w_tgt_locked;
    logic                w_cfg_ok;
    logic [CNT_W-1:0]    w_cnt_post;

    // Scanning from the top index down leaves the lowest matching entry in control.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_min = 2'd0;
        for (int i = NUM_REGION - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_addr[i] == req_addr_i)) begin
                w_hit     = 1'b1;
                w_hit_min = r_min_priv[i];
            end
        end
        if (!req_read_i && !req_write_i)
            w_deny = 1'b0;
        else if (w_hit)
            w_deny = (req_priv_i < w_hit_min);
        else
            w_deny = (req_priv_i != 2'd3);
    end

    always_comb begin
        w_idx_ok     = 1'b0;
        w_tgt_locked = 1'b0;
        for (int i = 0; i < NUM_REGION; i++) begin
            if (cfg_idx_i == IDX_W'(i)) begin
                w_idx_ok     = 1'b1;
                w_tgt_locked = r_lock[i];
            end
        end
        w_cfg_ok = cfg_we_i && (cfg_priv_i == 2'd3) && w_idx_ok && !w_tgt_locked;
    end

    assign w_cnt_post = (r_except && (r_viol_cnt != CNT_MAX)) ? r_viol_cnt + CNT_W'(1) : r_viol_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_except_o = 1'b0;
        locked_o     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    w_next = RESP;
            end
            RESP: begin
                rsp_valid_o  = 1'b1;
                rsp_except_o = r_except;
                if (clr_i)
                    w_next = IDLE;
                else if (w_cnt_post >= VIOL_LIM)
                    w_next = LOCK;
                else
                    w_next = IDLE;
            end
            LOCK: begin
                locked_o = 1'b1;
                if (clr_i)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // A clear always beats a violation landing in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_except   <= 1'b0;
            r_viol_cnt <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            if ((r_state == IDLE) && req_valid_i)
                r_except <= w_deny;
            if (clr_i)
                r_viol_cnt <= '0;
            else if (r_state == RESP)
                r_viol_cnt <= w_cnt_post;
            r_cfg_err <= cfg_we_i && !w_cfg_ok;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGION; i++) begin
                r_valid[i]    <= 1'b0;
                r_addr[i]     <= '0;
                r_min_priv[i] <= 2'd3;
                r_lock[i]     <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_REGION; i++) begin
                if (w_cfg_ok && (cfg_idx_i == IDX_W'(i))) begin
                    r_valid[i]    <= 1'b1;
                    r_addr[i]     <= cfg_addr_i;
                    r_min_priv[i] <= cfg_min_priv_i;
                    r_lock[i]     <= cfg_lock_i;
                end
            end
        end
    end

    assign cfg_err_o  = r_cfg_err;
    assign viol_cnt_o = r_viol_cnt;

endmodule

// File: tb/tb_priv_access_guard.sv
// Directed plus randomized bench for priv_access_guard, scored against a table-level
// reference model of the protection rules.
module tb_priv_access_guard;

    localparam int ADDR_W     = 12;
    localparam int NUM_REGION = 4;
    localparam int VIOL_MAX   = 3;
    localparam int CNT_W      = 4;
    localparam int IDX_W      = 2;
    localparam int CNT_SAT    = 15;

    logic              clk_i;
    logic              rst_ni;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_read_i;
    logic              req_write_i;
    logic [1:0]        req_priv_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic              rsp_valid_o;
    logic              rsp_except_o;
    logic              cfg_we_i;
    logic [1:0]        cfg_priv_i;
    logic [IDX_W-1:0]  cfg_idx_i;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic [1:0]        cfg_min_priv_i;
    logic              cfg_lock_i;
    logic              cfg_err_o;
    logic              clr_i;
    logic              locked_o;
    logic [CNT_W-1:0]  viol_cnt_o;

    int checks   = 0;
    int failures = 0;

    bit          mValid [NUM_REGION];
    logic [11:0] mAddr  [NUM_REGION];
    int          mMin   [NUM_REGION];
    bit          mLock  [NUM_REGION];
    int          mCnt;
    bit          mLocked;

    priv_access_guard #(
        .ADDR_W(ADDR_W), .NUM_REGION(NUM_REGION), .VIOL_MAX(VIOL_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_read_i(req_read_i), .req_write_i(req_write_i),
        .req_priv_i(req_priv_i), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_except_o(rsp_except_o),
        .cfg_we_i(cfg_we_i), .cfg_priv_i(cfg_priv_i), .cfg_idx_i(cfg_idx_i),
        .cfg_addr_i(cfg_addr_i), .cfg_min_priv_i(cfg_min_priv_i), .cfg_lock_i(cfg_lock_i),
        .cfg_err_o(cfg_err_o),
        .clr_i(clr_i), .locked_o(locked_o), .viol_cnt_o(viol_cnt_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bit modelExcept(input bit rd, input bit wr, input int priv, input logic [11:0] addr);
        if (!rd && !wr) return 1'b0;
        for (int i = 0; i < NUM_REGION; i++)
            if (mValid[i] && mAddr[i] == addr) return (priv < mMin[i]);
        return (priv != 3);
    endfunction

    function automatic bit modelCfgErr(input int priv, input int idx);
        if (priv != 3 || idx >= NUM_REGION) return 1'b1;
        return mLock[idx];
    endfunction

    task automatic modelCfgApply(input int priv, input int idx, input logic [11:0] addr,
                                 input int minp, input bit lock);
        if (!modelCfgErr(priv, idx)) begin
            mValid[idx] = 1'b1;
            mAddr[idx]  = addr;
            mMin[idx]   = minp;
            mLock[idx]  = lock;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NUM_REGION; i++) begin
            mValid[i] = 1'b0;
            mAddr[i]  = '0;
            mMin[i]   = 3;
            mLock[i]  = 1'b0;
        end
        mCnt    = 0;
        mLocked = 1'b0;
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_rsp_valid"}, rsp_valid_o, 0);
        checkOutput({tag, "_rsp_except"}, rsp_except_o, 0);
        checkOutput({tag, "_cfg_err"}, cfg_err_o, 0);
        checkOutput({tag, "_locked"}, locked_o, 0);
        checkOutput({tag, "_viol_cnt"}, viol_cnt_o, 0);
    endtask

    task automatic applyReset();
        rst_ni = 1'b0;
        req_valid_i = 0; req_read_i = 0; req_write_i = 0; req_priv_i = 0; req_addr_i = '0;
        cfg_we_i = 0; cfg_priv_i = 0; cfg_idx_i = '0; cfg_addr_i = '0;
        cfg_min_priv_i = 0; cfg_lock_i = 0; clr_i = 0;
        modelReset();
        stepCycle();
        stepCycle();
        checkQuiet("reset");
        rst_ni = 1'b1;
        stepCycle();
        checkOutput("reset_ready", req_ready_o, 1);
    endtask

    task automatic driveCfg(input int priv, input int idx, input logic [11:0] addr,
                            input int minp, input bit lock);
        cfg_we_i       = 1'b1;
        cfg_priv_i     = 2'(priv);
        cfg_idx_i      = 2'(idx);
        cfg_addr_i     = addr;
        cfg_min_priv_i = 2'(minp);
        cfg_lock_i     = lock;
    endtask

    task automatic finishResp(input bit clrResp, input bit exp);
        if (clrResp)
            mCnt = 0;
        else if (exp && mCnt < CNT_SAT)
            mCnt++;
        mLocked = !clrResp && (mCnt >= VIOL_MAX);
        stepCycle();
        clr_i = 1'b0;
        checkOutput("rsp_done", rsp_valid_o, 0);
        checkOutput("viol_cnt", viol_cnt_o, mCnt);
        checkOutput("locked", locked_o, mLocked);
        checkOutput("ready_after", req_ready_o, !mLocked);
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input int priv,
                                 input logic [11:0] addr, input bit clrResp);
        bit exp;
        exp = modelExcept(rd, wr, priv, addr);
        req_valid_i = 1'b1;
        req_read_i  = rd;
        req_write_i = wr;
        req_priv_i  = 2'(priv);
        req_addr_i  = addr;
        checkOutput("ready_idle", req_ready_o, 1);
        stepCycle();
        req_valid_i = 1'b0;
        clr_i = clrResp;
        checkOutput("rsp_valid", rsp_valid_o, 1);
        checkOutput("rsp_except", rsp_except_o, exp);
        finishResp(clrResp, exp);
    endtask

    task automatic doConfig(input int priv, input int idx, input logic [11:0] addr,
                            input int minp, input bit lock);
        bit exp;
        exp = modelCfgErr(priv, idx);
        driveCfg(priv, idx, addr, minp, lock);
        stepCycle();
        cfg_we_i = 1'b0;
        checkOutput("cfg_err", cfg_err_o, exp);
        modelCfgApply(priv, idx, addr, minp, lock);
        stepCycle();
        checkOutput("cfg_err_pulse", cfg_err_o, 0);
    endtask

    task automatic doClear();
        clr_i = 1'b1;
        stepCycle();
        clr_i = 1'b0;
        mCnt = 0;
        mLocked = 1'b0;
        checkOutput("clr_cnt", viol_cnt_o, 0);
        checkOutput("clr_locked", locked_o, 0);
        checkOutput("clr_ready", req_ready_o, 1);
    endtask

    logic [11:0] addrPool [5];

    initial begin
        bit exp;
        int op;
        logic [11:0] a;

        addrPool[0] = 12'h064; addrPool[1] = 12'h100; addrPool[2] = 12'h300;
        addrPool[3] = 12'h3FF; addrPool[4] = 12'h065;

        applyReset();

        // Empty table: default deny for non-machine, allow for machine
        applyStimulus(1, 0, 0, 12'h064, 0);
        applyStimulus(1, 0, 3, 12'h064, 0);
        doClear();

        // Entry0 guards 0x064 at min priv 1
        doConfig(3, 0, 12'h064, 1, 0);
        applyStimulus(0, 1, 1, 12'h064, 0);
        applyStimulus(0, 1, 0, 12'h064, 0);
        applyStimulus(0, 1, 1, 12'h065, 0);
        applyStimulus(1, 0, 2, 12'h065, 0);
        checkOutput("lock_ready", req_ready_o, 0);

        // Requests are ignored in lockout, config still works
        req_valid_i = 1'b1; req_read_i = 1'b1; req_priv_i = 2'd3; req_addr_i = 12'h064;
        stepCycle();
        stepCycle();
        req_valid_i = 1'b0;
        checkOutput("lock_no_rsp", rsp_valid_o, 0);
        checkOutput("lock_held", locked_o, 1);
        doConfig(3, 1, 12'h100, 2, 1);
        checkOutput("lock_after_cfg", locked_o, 1);
        doClear();

        // No read/write never excepts
        applyStimulus(0, 0, 0, 12'h7AB, 0);

        // Locked entry1 cannot be rewritten; non-machine writers are refused
        doConfig(3, 1, 12'h200, 0, 0);
        doConfig(1, 2, 12'h300, 0, 0);
        applyStimulus(1, 0, 1, 12'h100, 0);
        applyStimulus(1, 0, 2, 12'h100, 0);
        applyStimulus(1, 0, 2, 12'h200, 0);
        doClear();

        // Request accepted together with a config write sees the old table
        exp = modelExcept(1, 0, 2, 12'h300);
        req_valid_i = 1'b1; req_read_i = 1'b1; req_write_i = 1'b0;
        req_priv_i = 2'd2; req_addr_i = 12'h300;
        driveCfg(3, 2, 12'h300, 0, 0);
        stepCycle();
        req_valid_i = 1'b0;
        cfg_we_i = 1'b0;
        checkOutput("same_cyc_rsp", rsp_valid_o, 1);
        checkOutput("same_cyc_except", rsp_except_o, exp);
        checkOutput("same_cyc_cfg_err", cfg_err_o, 0);
        modelCfgApply(3, 2, 12'h300, 0, 0);
        finishResp(0, exp);
        applyStimulus(1, 0, 2, 12'h300, 0);
        doClear();

        // Clear coinciding with the third denied response wins
        applyStimulus(1, 0, 0, 12'h555, 0);
        applyStimulus(1, 0, 0, 12'h555, 0);
        applyStimulus(1, 0, 0, 12'h555, 1);

        // Randomized mix of requests, config writes and clears
        for (int k = 0; k < 120; k++) begin
            if (mLocked) begin
                doClear();
            end else begin
                op = $urandom_range(0, 9);
                a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addrPool[$urandom_range(0, 4)];
                if (op < 3)
                    doConfig($urandom_range(0, 3), $urandom_range(0, 3), a,
                             $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
                else if (op == 3)
                    doClear();
                else
                    applyStimulus($urandom_range(0, 1), $urandom_range(0, 1),
                                  $urandom_range(0, 3), a, ($urandom_range(0, 7) == 0));
            end
        end
        if (mLocked) doClear();

        // Reset mid-response drops the response
        applyStimulus(1, 0, 0, 12'h555, 0);
        req_valid_i = 1'b1; req_read_i = 1'b1; req_priv_i = 2'd0; req_addr_i = 12'h555;
        stepCycle();
        req_valid_i = 1'b0;
        checkOutput("pre_rst_rsp", rsp_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        checkQuiet("rst_resp");
        stepCycle();
        rst_ni = 1'b1;
        modelReset();
        stepCycle();
        checkQuiet("post_rst");
        checkOutput("post_rst_ready", req_ready_o, 1);
        applyStimulus(1, 0, 1, 12'h064, 0);

        // Reset in lockout releases it
        applyStimulus(1, 0, 1, 12'h064, 0);
        applyStimulus(1, 0, 1, 12'h064, 0);
        checkOutput("pre_rst_lock", locked_o, 1);
        rst_ni = 1'b0;
        #1;
        checkQuiet("rst_lock");
        stepCycle();
        rst_ni = 1'b1;
        modelReset();
        stepCycle();
        checkOutput("rst_lock_ready", req_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/priv_access_guard.md
PRIV_ACCESS_GUARD -- requirements
Module: priv_access_guard

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, request/config address width.
REQ-002 SHALL have parameter NUM_REGION, default 4, protected-register table entries (IDX_W = max(1,$clog2(NUM_REGION))).
REQ-003 SHALL have parameter VIOL_MAX, default 3, violations before lockout (1..2**CNT_W-1).
REQ-004 SHALL have parameter CNT_W, default 4, violation counter width.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async reset, active low.
REQ-006 SHALL have the request ports: req_valid_i in 1 request present; req_ready_o out 1 request accepted; req_read_i in 1 read; req_write_i in 1 write; req_priv_i in 2 requester privilege (3 = machine); req_addr_i in ADDR_W target register.
REQ-007 SHALL have the response ports: rsp_valid_o out 1 decision valid; rsp_except_o out 1 access denied.
REQ-008 SHALL have the config ports: cfg_we_i in 1 table write; cfg_priv_i in 2 writer privilege; cfg_idx_i in IDX_W entry; cfg_addr_i in ADDR_W register address; cfg_min_priv_i in 2 minimum privilege; cfg_lock_i in 1 lock entry; cfg_err_o out 1 rejected write.
REQ-009 SHALL have the status ports: clr_i in 1 clear lockout; locked_o out 1 lockout active; viol_cnt_o out CNT_W violation count.

Function
REQ-010 Each table entry SHALL hold valid, addr, min_priv and lock bits.
REQ-011 FSM SHALL have states IDLE, RESP and LOCK; req_ready_o SHALL be 1 only in IDLE.
REQ-012 IDLE: req_valid_i=1 SHALL accept the request, register the decision and go to RESP.
REQ-013 RESP SHALL drive rsp_valid_o=1 for exactly one cycle (latency 1, no backpressure), then go to LOCK if the post-update viol_cnt >= VIOL_MAX, else to IDLE.
REQ-014 Accesses with req_read_i=0 and req_write_i=0 SHALL produce a response with rsp_except_o=0.
REQ-015 A read or write matching a valid entry (req_addr_i == addr, lowest matching index wins) SHALL except iff req_priv_i < min_priv (unsigned full-width compare).
REQ-016 A read or write matching no valid entry SHALL except iff req_priv_i != 3; there is no address exemption (default deny).
REQ-017 Every excepting response SHALL increment viol_cnt, saturating at 2**CNT_W-1.
REQ-018 LOCK SHALL hold locked_o=1, ignore req_valid_i and return to IDLE only on clr_i=1.
REQ-019 clr_i=1 in any state SHALL zero viol_cnt next cycle; in LOCK it SHALL also go to IDLE; if clr_i coincides with an excepting response, the clear SHALL win (count 0, next state IDLE).
REQ-020 cfg_we_i with cfg_priv_i==3 to an unlocked entry SHALL write addr, min_priv and lock, set valid, and take effect the next cycle.
REQ-021 cfg_we_i with cfg_priv_i!=3, a locked target entry, or cfg_idx_i>=NUM_REGION SHALL leave the table unchanged and pulse cfg_err_o=1 for one cycle.
REQ-022 A request accepted in the same cycle as a config write SHALL be decided against the pre-write table.
REQ-023 Config writes SHALL be accepted in every FSM state, including LOCK.

Reset
REQ-024 rst_ni=0 SHALL immediately force: state IDLE, all entries valid=0/lock=0/min_priv=3/addr=0, viol_cnt=0, rsp_valid_o=0, rsp_except_o=0, cfg_err_o=0, locked_o=0.
REQ-025 Reset asserted mid-RESP or in LOCK SHALL drop the pending response and lockout without emitting rsp_valid_o.

Verification
REQ-026 Empty table; read addr 0x064, priv 0 -> rsp_valid_o one cycle after accept, rsp_except_o=1, viol_cnt_o=1; same read with priv 3 -> except 0.
REQ-027 Entry0={0x064, min_priv 1}; write 0x064, priv 1 -> except 0; priv 0 -> except 1; 0x065, priv 1 -> except 1.
REQ-028 Three denied accesses, VIOL_MAX=3 -> locked_o=1, req_ready_o=0; clr_i pulse -> IDLE, viol_cnt_o=0.
REQ-029 Entry1 written with lock=1, then rewritten by priv 3 -> table unchanged, cfg_err_o pulse; write by priv 1 -> cfg_err_o pulse.
REQ-030 clr_i in the cycle of the third denied response -> viol_cnt_o=0, locked_o stays 0; rst_ni low in RESP -> no rsp_valid_o, all outputs 0.
